// File: rtl/qpp_interleave_buffer.sv
// Single-buffer LTE QPP interleaver: fill one block of K LLRs, then replay as pi(i)=(f1*i+f2*i^2) mod K.
// Latency: first output beat 2 cycles after the first DRAIN cycle (sync RAM read + output register).
// Backpressure: none downstream; upstream is told via ready (FILL only). Define QPP_DEINTERLEAVE_EN to add deint.
module qpp_interleave_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int MAX_K  = 6144
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       blklen,
  input  logic              valid_blklen,
`ifdef QPP_DEINTERLEAVE_EN
  input  logic              deint,
`endif
  input  logic [DATA_W-1:0] extrinsic,
  input  logic              valid_extrinsic,
  output logic              ready,
  output logic [DATA_W-1:0] apriori_out,
  output logic              valid_apriori_out,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  // Per-K constants: K, K-1, g(0)=(f1+f2) mod K and the g increment 2*f2 mod K.
  localparam logic [ADDR_W:0]   K_S    = (ADDR_W+1)'(512);
  localparam logic [ADDR_W:0]   K_L    = (ADDR_W+1)'(6144);
  localparam logic [ADDR_W-1:0] KL_S   = ADDR_W'(511);
  localparam logic [ADDR_W-1:0] KL_L   = ADDR_W'(6143);
  localparam logic [ADDR_W-1:0] G0_S   = ADDR_W'((31 + 64) % 512);
  localparam logic [ADDR_W-1:0] G0_L   = ADDR_W'((263 + 480) % 6144);
  localparam logic [ADDR_W-1:0] STEP_S = ADDR_W'((2 * 64) % 512);
  localparam logic [ADDR_W-1:0] STEP_L = ADDR_W'((2 * 480) % 6144);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   k_q;
  logic [ADDR_W-1:0] klast_q;
  logic [ADDR_W-1:0] g0_q;
  logic [ADDR_W-1:0] step_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] pi_q;
  logic [ADDR_W-1:0] g_q;
  logic              err_q, err_d;
  logic              rd_vld_q;
  logic [DATA_W-1:0] rd_dat_q;
  logic              out_vld_q;
  logic [DATA_W-1:0] out_q;
  logic              deint_q;

  logic [DATA_W-1:0] ram [MAX_K];

  logic              blk_ok;
  logic              blk_small;
  logic              accept;
  logic              in_fill;
  logic              in_drain;
  logic              wr_en;
  logic              last;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   pi_sum;
  logic [ADDR_W:0]   g_sum;
  logic [ADDR_W-1:0] pi_step;
  logic [ADDR_W-1:0] g_step;

  assign blk_small = (blklen == 16'd512);
  assign blk_ok    = blk_small || (blklen == 16'd6144);
  assign accept    = (state_q == S_IDLE) && valid_blklen && blk_ok;
  assign in_fill   = (state_q == S_FILL);
  assign in_drain  = (state_q == S_DRAIN);
  assign wr_en     = in_fill && valid_extrinsic;
  assign last      = (cnt_q == klast_q);

  // Interleaved addressing: in de-interleave mode the permutation moves to the write side.
  assign wr_addr = deint_q ? pi_q  : cnt_q;
  assign rd_addr = deint_q ? cnt_q : pi_q;

  // Multiplier-free QPP recursion; operands are both < K so one conditional subtract suffices.
  always_comb begin
    pi_sum  = {1'b0, pi_q} + {1'b0, g_q};
    g_sum   = {1'b0, g_q} + {1'b0, step_q};
    pi_step = (pi_sum >= k_q) ? ADDR_W'(pi_sum - k_q) : ADDR_W'(pi_sum);
    g_step  = (g_sum  >= k_q) ? ADDR_W'(g_sum  - k_q) : ADDR_W'(g_sum);
  end

  // Next-state: the last write or last read issued ends its phase; FLUSH waits out the read pipe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)          state_d = S_FILL;
      S_FILL:  if (wr_en && last)   state_d = S_DRAIN;
      S_DRAIN: if (last)            state_d = S_FLUSH;
      S_FLUSH: if (!rd_vld_q)       state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // Sticky error: a good blklen in IDLE clears it, any protocol violation sets it.
  always_comb begin
    err_d = err_q;
    if (valid_blklen) begin
      if (state_q == S_IDLE) err_d = !blk_ok;
      else                   err_d = 1'b1;
    end
    if (valid_extrinsic && !in_fill) err_d = 1'b1;
  end

  // Control state, block parameters, counter and address recursion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      klast_q <= '0;
      g0_q    <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      pi_q    <= '0;
      g_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        k_q     <= blk_small ? K_S    : K_L;
        klast_q <= blk_small ? KL_S   : KL_L;
        g0_q    <= blk_small ? G0_S   : G0_L;
        step_q  <= blk_small ? STEP_S : STEP_L;
        g_q     <= blk_small ? G0_S   : G0_L;
        cnt_q   <= '0;
        pi_q    <= '0;
      end else if (wr_en) begin
        if (last) begin
          // Restart the recursion for the drain pass.
          cnt_q <= '0;
          pi_q  <= '0;
          g_q   <= g0_q;
        end else begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (deint_q) begin
            pi_q <= pi_step;
            g_q  <= g_step;
          end
        end
      end else if (in_drain) begin
        cnt_q <= last ? '0 : cnt_q + ADDR_W'(1);
        pi_q  <= pi_step;
        g_q   <= g_step;
      end
    end
  end

`ifdef QPP_DEINTERLEAVE_EN
  // Mode bit travels with the block length.
  always_ff @(posedge clk) begin
    if (rst)         deint_q <= 1'b0;
    else if (accept) deint_q <= deint;
  end
`else
  assign deint_q = 1'b0;
`endif

  // Block RAM: one write port in FILL, one synchronous read port in DRAIN.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= extrinsic;
    if (in_drain) rd_dat_q <= ram[rd_addr];
  end

  // Read-valid and output register; output data holds between bursts.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      rd_vld_q  <= in_drain;
      out_vld_q <= rd_vld_q;
      if (rd_vld_q) out_q <= rd_dat_q;
    end
  end

  assign ready             = in_fill;
  assign busy              = (state_q != S_IDLE);
  assign err               = err_q;
  assign apriori_out       = out_q;
  assign valid_apriori_out = out_vld_q;

endmodule

// File: tb/tb_qpp_interleave_buffer.sv
// Directed bench for qpp_interleave_buffer: control vector table plus full-block sequences.
// Expected interleaved data comes from a direct-formula QPP model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_qpp_interleave_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] blklen;
  logic        valid_blklen;
  logic [15:0] extrinsic;
  logic        valid_extrinsic;
  logic        ready;
  logic [15:0] apriori_out;
  logic        valid_apriori_out;
  logic        busy;
  logic        err;
`ifdef QPP_DEINTERLEAVE_EN
  logic        deint;
`endif

  int n_vec = 0;
  int n_bad = 0;

  int din  [6144];
  int expv [6144];
  int dout_q [$];

  qpp_interleave_buffer #(.DATA_W(16), .ADDR_W(13), .MAX_K(6144)) dut (
    .clk               (clk),
    .rst               (rst),
    .blklen            (blklen),
    .valid_blklen      (valid_blklen),
`ifdef QPP_DEINTERLEAVE_EN
    .deint             (deint),
`endif
    .extrinsic         (extrinsic),
    .valid_extrinsic   (valid_extrinsic),
    .ready             (ready),
    .apriori_out       (apriori_out),
    .valid_apriori_out (valid_apriori_out),
    .busy              (busy),
    .err               (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit vb;
    int bl;
    bit ve;
    int ext;
    bit e_rdy;
    bit e_busy;
    bit e_err;
    bit e_vout;
    int e_aout;
  } vec_t;

  vec_t tv[11];

  task automatic check(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic int qpp(input int k, input int i);
    longint f1, f2, li;
    f1 = (k == 512) ? 31 : 263;
    f2 = (k == 512) ? 64 : 480;
    li = i;
    return int'((f1 * li + f2 * li * li) % longint'(k));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one complete block: announce, fill from din[], drain into dout_q.
  task automatic run_block(input int k, input bit gap, input bit inject, input bit dei,
                           input bit exp_err, input string tag);
    int rlo, first, nv, rises, mism, lastv;
    bit prev, inj_on;
    dout_q.delete();
    for (int i = 0; i < k; i++) begin
      if (dei) expv[qpp(k, i)] = din[i];
      else     expv[i] = din[qpp(k, i)];
    end
    valid_blklen = 1'b1;
    blklen = 16'(k);
`ifdef QPP_DEINTERLEAVE_EN
    deint = dei;
`endif
    tick();
    valid_blklen = 1'b0;
    check({tag, "_acc_ready"}, int'(ready), 1);
    check({tag, "_acc_busy"}, int'(busy), 1);
    check({tag, "_acc_err"}, int'(err), 0);
    rlo = 0;
    for (int i = 0; i < k; i++) begin
      if (!ready) rlo++;
      valid_extrinsic = 1'b1;
      extrinsic = 16'(din[i]);
      tick();
      valid_extrinsic = 1'b0;
      if (gap && i != k - 1) tick();
    end
    check({tag, "_fill_ready_low"}, rlo, 0);
    check({tag, "_ready_fall"}, int'(ready), 0);
    first = -1; nv = 0; rises = 0; mism = 0; prev = 1'b0; lastv = 0; inj_on = 1'b0;
    for (int c = 0; c < k + 40; c++) begin
      if (c > 0) tick();
      if (inj_on) begin
        valid_extrinsic = 1'b0;
        inj_on = 1'b0;
      end
      if (inject && c == 5) begin
        valid_extrinsic = 1'b1;
        extrinsic = 16'h7fff;
        inj_on = 1'b1;
      end
      if (valid_apriori_out) begin
        if (first < 0) first = c;
        if (!prev) rises++;
        if (nv < k && int'(apriori_out) != expv[nv]) mism++;
        dout_q.push_back(int'(apriori_out));
        lastv = int'(apriori_out);
        nv++;
      end
      prev = valid_apriori_out;
      if (!busy && c > 2) break;
    end
    check({tag, "_first_beat_cycle"}, first, 2);
    check({tag, "_beats"}, nv, k);
    check({tag, "_valid_runs"}, rises, 1);
    check({tag, "_seq_miscompares"}, mism, 0);
    check({tag, "_busy_end"}, int'(busy), 0);
    tick();
    check({tag, "_hold_last"}, int'(apriori_out), lastv);
    check({tag, "_err_end"}, int'(err), int'(exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dup;
    bit seen [512];

    rst = 1'b1; blklen = '0; valid_blklen = 1'b0; extrinsic = '0; valid_extrinsic = 1'b0;
`ifdef QPP_DEINTERLEAVE_EN
    deint = 1'b0;
`endif

    //          rst vb  bl    ve ext  rdy busy err vout aout
    tv[0]  = '{1'b1, 1'b0, 0,    1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tv[1]  = '{1'b0, 1'b0, 0,    1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tv[2]  = '{1'b0, 1'b0, 0,    1'b1, 9, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tv[3]  = '{1'b0, 1'b1, 512,  1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tv[4]  = '{1'b0, 1'b0, 0,    1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tv[5]  = '{1'b0, 1'b1, 512,  1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    tv[6]  = '{1'b1, 1'b0, 0,    1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tv[7]  = '{1'b0, 1'b1, 1000, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tv[8]  = '{1'b0, 1'b0, 0,    1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tv[9]  = '{1'b0, 1'b1, 512,  1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tv[10] = '{1'b1, 1'b0, 0,    1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    for (int v = 0; v < 11; v++) begin
      rst = tv[v].rst;
      valid_blklen = tv[v].vb;
      blklen = 16'(tv[v].bl);
      valid_extrinsic = tv[v].ve;
      extrinsic = 16'(tv[v].ext);
      tick();
      check($sformatf("tv%0d_ready", v), int'(ready), int'(tv[v].e_rdy));
      check($sformatf("tv%0d_busy", v), int'(busy), int'(tv[v].e_busy));
      check($sformatf("tv%0d_err", v), int'(err), int'(tv[v].e_err));
      check($sformatf("tv%0d_vout", v), int'(valid_apriori_out), int'(tv[v].e_vout));
      check($sformatf("tv%0d_aout", v), int'(apriori_out), tv[v].e_aout);
    end
    rst = 1'b0; valid_blklen = 1'b0; valid_extrinsic = 1'b0;
    tick();

    // K=512, identity data, continuous valid.
    for (int i = 0; i < 6144; i++) din[i] = i;
    run_block(512, 1'b0, 1'b0, 1'b0, 1'b0, "k512");
    check("k512_o0", dout_q[0], 0);
    check("k512_o1", dout_q[1], 95);
    check("k512_o2", dout_q[2], 318);
    check("k512_o3", dout_q[3], 157);
    dup = 0;
    foreach (seen[j]) seen[j] = 1'b0;
    foreach (dout_q[j]) begin
      if (dout_q[j] < 512 && !seen[dout_q[j]]) seen[dout_q[j]] = 1'b1;
      else dup++;
    end
    check("k512_perm_dups", dup, 0);

`ifdef QPP_DEINTERLEAVE_EN
    // Feed the interleaved stream back through a de-interleave pass.
    for (int i = 0; i < 512; i++) din[i] = dout_q[i];
    run_block(512, 1'b0, 1'b0, 1'b1, 1'b0, "deint");
    dup = 0;
    foreach (dout_q[j]) if (dout_q[j] != j) dup++;
    check("deint_natural_order", dup, 0);
    check("deint_size", dout_q.size(), 512);
    for (int i = 0; i < 6144; i++) din[i] = i;
`endif

    // K=6144, valid on every other cycle.
    run_block(6144, 1'b1, 1'b0, 1'b0, 1'b0, "k6144");
    check("k6144_o1", dout_q[1], 743);
    check("k6144_o2", dout_q[2], 2446);
    check("k6144_o3", dout_q[3], 5109);

    // Stray extrinsic during DRAIN: dropped, err set, stream intact.
    for (int i = 0; i < 512; i++) din[i] = (i * 37 + 11) % 30000;
    run_block(512, 1'b0, 1'b1, 1'b0, 1'b1, "inject");

    // Reset at write 300 of a K=6144 block, then a clean K=512 block.
    for (int i = 0; i < 6144; i++) din[i] = i;
    valid_blklen = 1'b1; blklen = 16'd6144;
    tick();
    valid_blklen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      valid_extrinsic = 1'b1; extrinsic = 16'(i);
      tick();
    end
    extrinsic = 16'd300; rst = 1'b1;
    tick();
    rst = 1'b0; valid_extrinsic = 1'b0;
    check("abort_ready", int'(ready), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_err", int'(err), 0);
    check("abort_vout", int'(valid_apriori_out), 0);
    check("abort_aout", int'(apriori_out), 0);
    tick();
    run_block(512, 1'b0, 1'b0, 1'b0, 1'b0, "after_abort");
    check("after_abort_o3", dout_q[3], 157);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/qpp_interleave_buffer.md
Name: qpp_interleave_buffer

Overview:
- Sits directly downstream of the SISO decoder's extrinsic output (`extrinsic`/`valid_extrinsic`).
- Captures one block of K extrinsic LLRs in natural order, then replays them in LTE QPP-interleaved order, pi(i) = (f1*i + f2*i^2) mod K, as a priori input to the second constituent SISO.
- Single-buffer design: fill phase, then drain phase.
- Supported K: 512 (f1=31, f2=64) and 6144 (f1=263, f2=480).

Parameters:
- DATA_W, 16, LLR sample width (signed two's complement, passed through unmodified).
- ADDR_W, 13, index/address width; must satisfy 2^ADDR_W >= MAX_K.
- MAX_K, 6144, buffer depth in samples.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- blklen  in  16  block length K; sampled when valid_blklen=1.
- valid_blklen  in  1  one-cycle strobe announcing a new block.
- extrinsic  in  DATA_W  extrinsic LLR from the SISO, natural order.
- valid_extrinsic  in  1  qualifies extrinsic.
- ready  out  1  high while the buffer accepts input (FILL state).
- apriori_out  out  DATA_W  interleaved LLR.
- valid_apriori_out  out  1  qualifies apriori_out.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky error flag; cleared only by rst or the next accepted valid_blklen.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; ready=0, valid_apriori_out=0, apriori_out=0, busy=0, err=0; all counters cleared.
  - rst mid-operation aborts the block immediately. RAM contents are don't-care.
- States: IDLE, FILL, DRAIN, FLUSH.
- IDLE:
  - valid_blklen=1 with blklen=512 or 6144: latch K, f1 and f2; clear err; go to FILL next cycle.
  - valid_blklen=1 with any other blklen: set err; stay IDLE.
  - valid_extrinsic in IDLE: sample ignored, err set.
- FILL:
  - ready=1.
  - Each valid_extrinsic writes RAM[wr_cnt] and increments wr_cnt. Gaps in valid are allowed.
  - The write with wr_cnt=K-1 moves the state to DRAIN on the next cycle; ready drops in that same next cycle.
  - valid_blklen in FILL or DRAIN is ignored and sets err.
- DRAIN:
  - Issues one read per cycle for K cycles at address pi(rd_cnt), rd_cnt = 0..K-1.
  - pi is computed recursively, with no multipliers:
    - pi(0)=0, g(0)=(f1+f2) mod K.
    - pi(i+1)=(pi(i)+g(i)) mod K; g(i+1)=(g(i)+2*f2) mod K.
    - Each mod is a single conditional subtract of K on an (ADDR_W+1)-bit sum, since both operands are < K.
    - 2*f2 mod K is precomputed at latch time.
  - After the read for rd_cnt=K-1 is issued, go to FLUSH.
- FLUSH:
  - Waits for the 2-cycle read pipeline to empty, then returns to IDLE.
  - valid_extrinsic arriving outside FILL is dropped and sets err.
- Output timing:
  - Synchronous RAM read (1 cycle) plus output register (1 cycle).
  - The first apriori_out beat appears 2 cycles after the first DRAIN cycle.
  - valid_apriori_out is high for exactly K consecutive cycles.
  - apriori_out holds its last value when valid_apriori_out=0.
- Back-to-back blocks: a valid_blklen arriving in the same cycle the state returns to IDLE is not seen. It must arrive when busy=0 (IDLE).
- No downstream backpressure: the consumer must accept one sample per cycle.

Optional Feature:
- Macro: QPP_DEINTERLEAVE_EN.
- Defined:
  - Adds input port `deint` (1 bit), sampled together with valid_blklen.
  - deint=1: FILL writes RAM[pi(wr_cnt)] using the same recursion, and DRAIN reads sequential addresses 0..K-1. This de-interleaves the second SISO's extrinsic output for feedback to the first SISO.
  - deint=0: behaviour identical to the undefined case.
- Undefined: no `deint` port; the block interleaves only.

Test Plan:
- K=512, extrinsic[i]=i for i=0..511, continuous valid → ready falls after 512 writes; outputs begin at 0, 95, 318, 157; 512 beats total; output set is a permutation of 0..511.
- K=6144, extrinsic[i]=i, valid gapped 1-of-2 cycles → outputs begin at 0, 743, 2446, 5109; valid_apriori_out high for exactly 6144 contiguous cycles; err=0.
- blklen=1000 with valid_blklen → err=1, state stays IDLE, busy=0; a following valid_blklen with blklen=512 clears err and enters FILL.
- rst asserted at write 300 of a K=6144 block → next cycle all outputs at reset values; a new K=512 block then completes correctly.
- valid_extrinsic during DRAIN → sample dropped, err=1, output sequence unaffected.
- With QPP_DEINTERLEAVE_EN: interleave pass output fed into a deint=1 pass (K=512) → final output equals 0..511 in natural order.
